// File: rtl/bcd_complement_sequencer_if.sv
// Handshake and data bundle between an operand source and the decimal
// complement sequencer. The master drives the request and operand; the
// slave (the sequencer) returns status and the complemented result.
interface bcd_complement_sequencer_if #(
    parameter int DIGITS = 4
);
    logic                  START;
    logic                  MODE;
    logic                  CODE_SEL;
    logic [4*DIGITS-1:0]   DIN;
    logic                  BUSY;
    logic                  DONE;
    logic [4*DIGITS-1:0]   DOUT;
    logic                  CARRY;
    logic                  ERR;

    modport master (
        output START, MODE, CODE_SEL, DIN,
        input  BUSY, DONE, DOUT, CARRY, ERR
    );

    modport slave (
        input  START, MODE, CODE_SEL, DIN,
        output BUSY, DONE, DOUT, CARRY, ERR
    );
endinterface

// File: rtl/bcd_complement_sequencer.sv
// Multi-digit decimal nine's/ten's complementer. A single-digit datapath is
// stepped across the latched operand least-significant digit first, one digit
// per clock, with decimal carry propagation. Digits may be 8421 BCD or the
// Gray-style decimal code; the result uses the same code as the operand.
module bcd_complement_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    bcd_complement_sequencer_if.slave    bus
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Returns {valid, value}; value is forced to 0 for an invalid code so the
    // downstream subtraction never wraps.
    function automatic logic [4:0] decode_digit(input logic [3:0] c, input logic gray);
        logic [4:0] r;
        r = 5'b0_0000;
        if (!gray) begin
            if (c <= 4'd9) r = {1'b1, c};
        end else begin
            case (c)
                4'b0000: r = {1'b1, 4'd0};
                4'b0001: r = {1'b1, 4'd1};
                4'b0011: r = {1'b1, 4'd2};
                4'b0010: r = {1'b1, 4'd3};
                4'b0110: r = {1'b1, 4'd4};
                4'b0111: r = {1'b1, 4'd5};
                4'b0101: r = {1'b1, 4'd6};
                4'b0100: r = {1'b1, 4'd7};
                4'b1100: r = {1'b1, 4'd8};
                4'b1101: r = {1'b1, 4'd9};
                default: r = 5'b0_0000;
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] encode_digit(input logic [3:0] v, input logic gray);
        logic [3:0] c;
        if (!gray) begin
            c = v;
        end else begin
            case (v)
                4'd0:    c = 4'b0000;
                4'd1:    c = 4'b0001;
                4'd2:    c = 4'b0011;
                4'd3:    c = 4'b0010;
                4'd4:    c = 4'b0110;
                4'd5:    c = 4'b0111;
                4'd6:    c = 4'b0101;
                4'd7:    c = 4'b0100;
                4'd8:    c = 4'b1100;
                4'd9:    c = 4'b1101;
                default: c = 4'b1111;
            endcase
        end
        return c;
    endfunction

    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [W-1:0]       opnd_q,   opnd_d;
    logic               code_q,   code_d;
    logic               carry_q,  carry_d;
    logic               err_q,    err_d;
    logic [W-1:0]       res_q,    res_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [W-1:0]       dout_q,   dout_d;
    logic               cout_q,   cout_d;
    logic               errout_q, errout_d;

    logic [4:0]         dec;
    logic [4:0]         sum;
    logic [3:0]         dig;
    logic               dig_carry;
    logic               dig_err;
    logic [W+3:0]       shifted;

    // Single-digit complement of the current low digit of the operand register.
    always_comb begin
        dec       = decode_digit(opnd_q[3:0], code_q);
        sum       = 5'd9 - {1'b0, dec[3:0]} + {4'b0000, carry_q};
        dig       = 4'b1111;
        dig_carry = 1'b0;
        dig_err   = 1'b0;
        if (!dec[4]) begin
            dig_err = 1'b1;
        end else if (sum == 5'd10) begin
            dig       = encode_digit(4'd0, code_q);
            dig_carry = 1'b1;
        end else begin
            dig = encode_digit(sum[3:0], code_q);
        end
        shifted = {dig, res_q};
    end

    // Sequencer next-state and register-load decisions; outputs are loaded on
    // entry to FIN so they are valid in the same cycle DONE is high.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opnd_d   = opnd_q;
        code_d   = code_q;
        carry_d  = carry_q;
        err_d    = err_q;
        res_d    = res_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dout_d   = dout_q;
        cout_d   = cout_q;
        errout_d = errout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    opnd_d  = bus.DIN;
                    code_d  = bus.CODE_SEL;
                    carry_d = bus.MODE;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = shifted[W+3:4];
                opnd_d  = opnd_q >> 4;
                carry_d = dig_carry;
                err_d   = err_q | dig_err;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    dout_d   = shifted[W+3:4];
                    cout_d   = dig_carry;
                    errout_d = err_q | dig_err;
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, working and output registers; reset aborts any operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            opnd_q   <= '0;
            code_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
            cout_q   <= 1'b0;
            errout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opnd_q   <= opnd_d;
            code_q   <= code_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
            cout_q   <= cout_d;
            errout_q <= errout_d;
        end
    end

    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.DOUT  = dout_q;
    assign bus.CARRY = cout_q;
    assign bus.ERR   = errout_q;

endmodule

// File: tb/tb_bcd_complement_sequencer.sv
// Bench for the decimal complement sequencer (DIGITS = 4): directed vector
// table, multi-cycle corner sequences and randomized operands against an
// arithmetic reference model.
module tb_bcd_complement_sequencer;

    localparam int D   = 4;
    localparam int W   = 4 * D;
    localparam int WIN = D + 4;

    logic clk;
    logic rst;

    bcd_complement_sequencer_if #(.DIGITS(D)) bus ();

    bcd_complement_sequencer #(.DIGITS(D)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [3:0] gray_tab [10] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6,
                                  4'h7, 4'h5, 4'h4, 4'hC, 4'hD};

    typedef struct packed {
        logic [15:0] din;
        logic        mode;
        logic        code;
        logic [15:0] dout;
        logic        carry;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] enc(input int v, input logic code);
        logic [3:0] r;
        r = code ? gray_tab[v] : 4'(v);
        return r;
    endfunction

    // Reference: whole-number complement of the valid low part, nine's
    // complement above the lowest invalid digit, 4'hF for invalid digits.
    function automatic void model(input logic [15:0] din, input logic mode, input logic code,
                                  output logic [15:0] dout, output logic c, output logic e);
        int  val [D];
        bit  ok  [D];
        int  j;
        longint low, p, res_low, pw;
        logic [3:0] nib;
        j = D;
        for (int k = 0; k < D; k++) begin
            nib = din[4*k +: 4];
            ok[k] = 1'b0;
            val[k] = 0;
            if (!code) begin
                if (nib <= 4'd9) begin ok[k] = 1'b1; val[k] = int'(nib); end
            end else begin
                for (int v = 0; v < 10; v++)
                    if (gray_tab[v] == nib) begin ok[k] = 1'b1; val[k] = v; end
            end
            if (!ok[k] && j == D) j = k;
        end
        low = 0; p = 1;
        for (int k = 0; k < j; k++) begin
            low = low + longint'(val[k]) * p;
            p = p * 10;
        end
        res_low = mode ? ((p - low) % p) : (p - 1 - low);
        dout = '0;
        pw = 1;
        for (int k = 0; k < D; k++) begin
            if (k < j)       dout[4*k +: 4] = enc(int'((res_low / pw) % 10), code);
            else if (!ok[k]) dout[4*k +: 4] = 4'hF;
            else             dout[4*k +: 4] = enc(9 - val[k], code);
            pw = pw * 10;
        end
        e = (j < D);
        c = mode && !e && (low == 0);
    endfunction

    // Issue one START in IDLE, then change the inputs and optionally pulse
    // START in selected later cycles; observe a fixed window of cycles.
    task automatic run_op(input logic [W-1:0] din, input logic mode, input logic code,
                          input logic [W-1:0] din_after, input int start_mask,
                          output logic [W-1:0] dout, output logic c, output logic e,
                          output int done_at, output int n_done, output int n_busy,
                          output logic [W-1:0] dout_end);
        @(negedge clk);
        bus.START    = 1'b1;
        bus.DIN      = din;
        bus.MODE     = mode;
        bus.CODE_SEL = code;
        @(posedge clk);
        n_done = 0; n_busy = 0; done_at = -1;
        dout = '0; c = 1'b0; e = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            if (bus.BUSY) n_busy++;
            if (bus.DONE) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = i;
                    dout = bus.DOUT;
                    c = bus.CARRY;
                    e = bus.ERR;
                end
            end
            bus.START = start_mask[i];
            if (i == 0) begin
                bus.DIN      = din_after;
                bus.MODE     = ~mode;
                bus.CODE_SEL = ~code;
            end
        end
        dout_end = bus.DOUT;
        bus.START = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] dout, dout_end, din, exp_dout;
        logic c, e, exp_c, exp_e, mode, code;
        int done_at, n_done, n_busy, first_done, last_done;

        bus.START = 1'b0; bus.DIN = '0; bus.MODE = 1'b0; bus.CODE_SEL = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",  32'(bus.BUSY),  32'd0);
        chk("reset_done",  32'(bus.DONE),  32'd0);
        chk("reset_dout",  32'(bus.DOUT),  32'd0);
        chk("reset_carry", 32'(bus.CARRY), 32'd0);
        chk("reset_err",   32'(bus.ERR),   32'd0);
        rst = 1'b0;

        vecs[0] = '{16'h1234, 1'b0, 1'b0, 16'h8765, 1'b0, 1'b0};
        vecs[1] = '{16'h1234, 1'b1, 1'b0, 16'h8766, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0010, 1'b1, 1'b0, 16'h9990, 1'b0, 1'b0};
        vecs[4] = '{16'h0002, 1'b0, 1'b1, 16'hDDD5, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h12A4, 1'b0, 1'b0, 16'h87F5, 1'b0, 1'b1};
        vecs[7] = '{16'h0999, 1'b1, 1'b0, 16'h9001, 1'b0, 1'b0};

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].din, vecs[v].mode, vecs[v].code, ~vecs[v].din, 0,
                   dout, c, e, done_at, n_done, n_busy, dout_end);
            chk($sformatf("vec%0d_dout", v),    32'(dout),    32'(vecs[v].dout));
            chk($sformatf("vec%0d_carry", v),   32'(c),       32'(vecs[v].carry));
            chk($sformatf("vec%0d_err", v),     32'(e),       32'(vecs[v].err));
            chk($sformatf("vec%0d_latency", v), 32'(done_at), 32'(D));
            chk($sformatf("vec%0d_ndone", v),   32'(n_done),  32'd1);
            chk($sformatf("vec%0d_nbusy", v),   32'(n_busy),  32'(D + 1));
            chk($sformatf("vec%0d_hold", v),    32'(dout_end), 32'(vecs[v].dout));
        end

        // START pulsed in a RUN cycle and in the FIN cycle is ignored.
        run_op(16'h1234, 1'b0, 1'b0, 16'h5678, (1 << 1) | (1 << D),
               dout, c, e, done_at, n_done, n_busy, dout_end);
        chk("ign_dout",  32'(dout),   32'h8765);
        chk("ign_ndone", 32'(n_done), 32'd1);
        chk("ign_nbusy", 32'(n_busy), 32'(D + 1));

        // Reset in the second RUN cycle aborts without a DONE.
        @(negedge clk);
        bus.START = 1'b1; bus.DIN = 16'h0010; bus.MODE = 1'b1; bus.CODE_SEL = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.START = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",  32'(bus.BUSY),  32'd0);
        chk("abort_done",  32'(bus.DONE),  32'd0);
        chk("abort_dout",  32'(bus.DOUT),  32'd0);
        chk("abort_carry", 32'(bus.CARRY), 32'd0);
        rst = 1'b0;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            if (bus.DONE) n_done++;
            if (bus.BUSY) n_busy++;
        end
        chk("abort_ndone", 32'(n_done), 32'd0);
        chk("abort_nbusy", 32'(n_busy), 32'd0);
        run_op(16'h0010, 1'b1, 1'b0, 16'h0000, 0,
               dout, c, e, done_at, n_done, n_busy, dout_end);
        chk("post_abort_dout",  32'(dout),   32'h9990);
        chk("post_abort_carry", 32'(c),      32'd0);
        chk("post_abort_ndone", 32'(n_done), 32'd1);

        // START held high: a new operation every D+2 cycles.
        @(negedge clk);
        bus.START = 1'b1; bus.DIN = 16'h1234; bus.MODE = 1'b0; bus.CODE_SEL = 1'b0;
        @(posedge clk);
        n_done = 0; first_done = -1; last_done = -1;
        for (int i = 0; i < 3 * (D + 2); i++) begin
            @(negedge clk);
            if (bus.DONE) begin
                n_done++;
                if (first_done < 0) first_done = i;
                last_done = i;
            end
        end
        bus.START = 1'b0;
        chk("held_ndone", 32'(n_done),     32'd3);
        chk("held_first", 32'(first_done), 32'(D));
        chk("held_last",  32'(last_done),  32'(D + 2 * (D + 2)));
        repeat (2) @(negedge clk);
        chk("held_idle_busy", 32'(bus.BUSY), 32'd0);

        // Randomized operands against the reference model.
        for (int n = 0; n < 40; n++) begin
            mode = 1'($urandom_range(1));
            code = 1'($urandom_range(1));
            din = '0;
            if ($urandom_range(9) != 0) begin
                for (int k = 0; k < D; k++) begin
                    if ($urandom_range(7) == 0) din[4*k +: 4] = 4'($urandom_range(15));
                    else din[4*k +: 4] = enc(int'($urandom_range(9)), code);
                end
            end
            model(din, mode, code, exp_dout, exp_c, exp_e);
            run_op(din, mode, code, 16'($urandom), 0,
                   dout, c, e, done_at, n_done, n_busy, dout_end);
            chk($sformatf("rnd%0d_dout din=%h m=%0d g=%0d", n, din, mode, code),
                32'(dout), 32'(exp_dout));
            chk($sformatf("rnd%0d_carry", n),   32'(c),       32'(exp_c));
            chk($sformatf("rnd%0d_err", n),     32'(e),       32'(exp_e));
            chk($sformatf("rnd%0d_latency", n), 32'(done_at), 32'(D));
            chk($sformatf("rnd%0d_nbusy", n),   32'(n_busy),  32'(D + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
